ad7606_emu: RTL and testbench
=============================

Name: ad7606_emu

Overview:
- Synthesizable AD7606 device emulator, i.e. the slave end of the AD7606 parallel interface.
- Responds to CONVST/CS/RD/RESET from the existing AD7606 controller by driving BUSY, FIRSTDATA and a 16-bit data bus carrying deterministic per-channel test samples.
- Used for board-less bring-up of the acquisition path and in system sims, placed where the real ADC pins connect.

Parameters:
- CONV_CYCLES, 200, BUSY high time in clk cycles at ad_os=0.
- CNT_W, 16, width of conversion-time counter; must hold CONV_CYCLES<<6.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  reset; synchronous, active-high.
- ad_reset  in  1  device reset from controller, active-high.
- ad_convstab  in  1  conversion start; rising edge starts a conversion.
- ad_cs  in  1  chip select, active-low.
- ad_rd  in  1  read strobe, active-low.
- ad_os  in  3  oversampling ratio select.
- ad_busy  out  1  conversion in progress.
- first_data  out  1  high while CH1 is on ad_data.
- ad_data  out  16  sample data; driven, never tristated.
- conv_ovr  out  1  sticky flag, set when CONVST arrives while busy.

Behaviour:
- Reset: rst or ad_reset high → ad_busy=0, first_data=0, ad_data=0, conv_ovr=0, conv_cnt=0, channel pointer ptr=0, busy counter=0, all snapshot registers=0, convst_q=1, rd_q=1.
- Edge detect: convst_q and rd_q hold the previous-cycle ad_convstab and ad_rd.
  - conv_start = ad_convstab & ~convst_q.
  - rd_fall = ~ad_rd & rd_q & ~ad_cs.
- Conversion time: T = CONV_CYCLES << ad_os for ad_os in 0..6. ad_os=7 is treated as 0. ad_os is sampled at conv_start.
- FSM with three states, IDLE / CONV / DONE:
  - IDLE: on conv_start → CONV, ad_busy=1 from the next cycle, counter=T-1.
  - CONV: counter decrements each cycle. At counter==0 → DONE.
  - DONE (one cycle):
    - Latch snapshot[k] = {k[2:0], conv_cnt[12:0]} for k=0..7.
    - conv_cnt increments; it is 13-bit and wraps 8191→0.
    - ad_busy=0.
    - Go to IDLE.
  - BUSY high time is therefore exactly T+1 cycles.
- conv_start while in CONV or DONE:
  - The request is ignored and conv_ovr is set.
  - conv_ovr stays set until rst/ad_reset.
- Read:
  - On a cycle with rd_fall: next edge loads ad_data=snapshot[ptr], first_data=(ptr==0), and ptr=ptr+1 (3-bit, wraps 7→0).
  - ad_data/first_data hold their value until the next rd_fall.
  - Output latency is 1 cycle after ad_rd is first sampled low.
- ad_cs high:
  - ptr=0 and first_data=0 next cycle.
  - ad_data is held, not cleared.
  - rd_fall is suppressed.
- Reads during CONV return the previous conversion's snapshot; the snapshot is updated only in DONE.
- A DONE cycle coinciding with rd_fall: the read uses the old snapshot, and the new snapshot takes effect for subsequent reads.
- ad_reset mid-conversion: immediate return to IDLE with everything cleared as in reset. A conversion is not started by an ad_convstab that is already high when reset releases, because convst_q resets to 1.

Optional Feature:
- Macro: AD_EMU_NOISE_EN.
- Defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances once per DONE.
  - In DONE, snapshot[k][2:0] is XORed with lfsr[2:0]^k[2:0], giving a deterministic pseudo-noise LSB.
- Undefined: no LFSR logic and the snapshot is the exact pattern.

Test Plan:
1. Reset, then a 3-cycle low pulse on ad_convstab with ad_os=0 → ad_busy high exactly 201 cycles, starting 1 cycle after the rising edge is sampled.
2. After conversion 0, cs low plus 8 rd pulses (3 cycles low, 1 high) → ad_data = 16'h0000, 16'h2000, 16'h4000 … 16'hE000; first_data high only with the first word.
3. Second conversion then read → CH1=16'h0001, CH8=16'hE001. Set conv_cnt near 8191 by repeated conversions → wraps to 16'h0000/16'hE000.
4. ad_os=2 → busy width 801 cycles. ad_os=7 → 201 cycles.
5. CONVST pulse at cycle 50 of busy → busy width unchanged, conv_ovr=1 and stays 1. ad_reset pulse → conv_ovr=0, ad_busy=0 immediately, ad_data=0.
6. 10 reads within one cs low → first_data high on reads 1 and 9. cs high then low after 4 reads → the next read returns CH1 with first_data=1.

Source files
------------

// File: rtl/ad7606_emu.sv
// AD7606 parallel-interface slave emulator: BUSY timing, per-channel test samples, read sequencing.
// Define AD_EMU_NOISE_EN to add an LFSR-driven pseudo-noise LSB pattern to each snapshot.
module ad7606_emu #(
  parameter int CONV_CYCLES = 200,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ad_reset,
  input  logic        ad_convstab,
  input  logic        ad_cs,
  input  logic        ad_rd,
  input  logic [2:0]  ad_os,
  output logic        ad_busy,
  output logic        first_data,
  output logic [15:0] ad_data,
  output logic        conv_ovr
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [12:0]       conv_cnt_q, conv_cnt_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [15:0]       snap_q [8];
  logic [15:0]       snap_d [8];
  logic              busy_q, busy_d;
  logic              first_q, first_d;
  logic [15:0]       data_q, data_d;
  logic              ovr_q, ovr_d;
  logic              convst_q, rd_q;
`ifdef AD_EMU_NOISE_EN
  logic [15:0]       lfsr_q, lfsr_d;
`endif

  logic              conv_start;
  logic              rd_fall;
  logic [2:0]        os_eff;
  logic [CNT_W-1:0]  t_cyc;

  assign conv_start = ad_convstab & ~convst_q;
  assign rd_fall    = ~ad_rd & rd_q & ~ad_cs;
  assign os_eff     = (ad_os == 3'd7) ? 3'd0 : ad_os;
  assign t_cyc      = CNT_W'(CONV_CYCLES) << os_eff;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    conv_cnt_d = conv_cnt_q;
    ptr_d      = ptr_q;
    snap_d     = snap_q;
    busy_d     = busy_q;
    first_d    = first_q;
    data_d     = data_q;
`ifdef AD_EMU_NOISE_EN
    lfsr_d     = lfsr_q;
`endif
    // A start request outside IDLE is dropped but remembered
    ovr_d      = ovr_q | (conv_start & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (conv_start) begin
          state_d = CONV;
          busy_d  = 1'b1;
          cnt_d   = t_cyc - CNT_W'(1);
        end
      end
      CONV: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        for (int k = 0; k < 8; k++) begin
`ifdef AD_EMU_NOISE_EN
          snap_d[k] = {3'(k), conv_cnt_q}
                    ^ {13'd0, lfsr_q[2:0] ^ 3'(k)};
`else
          snap_d[k] = {3'(k), conv_cnt_q};
`endif
        end
`ifdef AD_EMU_NOISE_EN
        lfsr_d = {1'b0, lfsr_q[15:1]}
               ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`endif
        conv_cnt_d = conv_cnt_q + 13'd1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reads see snap_q, so a read in the DONE cycle gets the old sample
    if (ad_cs) begin
      ptr_d   = 3'd0;
      first_d = 1'b0;
    end else if (rd_fall) begin
      data_d  = snap_q[ptr_q];
      first_d = (ptr_q == 3'd0);
      ptr_d   = ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | ad_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      conv_cnt_q <= '0;
      ptr_q      <= '0;
      for (int k = 0; k < 8; k++) snap_q[k] <= '0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      data_q     <= '0;
      ovr_q      <= 1'b0;
      convst_q   <= 1'b1;
      rd_q       <= 1'b1;
`ifdef AD_EMU_NOISE_EN
      lfsr_q     <= 16'hACE1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conv_cnt_q <= conv_cnt_d;
      ptr_q      <= ptr_d;
      snap_q     <= snap_d;
      busy_q     <= busy_d;
      first_q    <= first_d;
      data_q     <= data_d;
      ovr_q      <= ovr_d;
      convst_q   <= ad_convstab;
      rd_q       <= ad_rd;
`ifdef AD_EMU_NOISE_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign ad_busy    = busy_q;
  assign first_data = first_q;
  assign ad_data    = data_q;
  assign conv_ovr   = ovr_q;

endmodule

// File: tb/tb_ad7606_emu.sv
// Directed bench for ad7606_emu: busy timing, read sequencing, overrun, reset, counter wrap.
// A second fast instance (CONV_CYCLES=1) walks the 13-bit sample counter through its wrap.
module tb_ad7606_emu;

  logic        clk;
  logic        rst;
  logic        ad_reset;
  logic        convstab;
  logic        cs;
  logic        rd;
  logic [2:0]  os;
  logic        busy;
  logic        fd;
  logic [15:0] data;
  logic        ovr;

  logic        f_convstab;
  logic        f_cs;
  logic        f_busy;
  logic        f_fd;
  logic [15:0] f_data;
  logic        f_ovr;

  int n_vec;
  int n_err;

  ad7606_emu u_dut (
    .clk        (clk),
    .rst        (rst),
    .ad_reset   (ad_reset),
    .ad_convstab(convstab),
    .ad_cs      (cs),
    .ad_rd      (rd),
    .ad_os      (os),
    .ad_busy    (busy),
    .first_data (fd),
    .ad_data    (data),
    .conv_ovr   (ovr)
  );

  ad7606_emu #(
    .CONV_CYCLES(1),
    .CNT_W      (8)
  ) u_fast (
    .clk        (clk),
    .rst        (rst),
    .ad_reset   (1'b0),
    .ad_convstab(f_convstab),
    .ad_cs      (f_cs),
    .ad_rd      (rd),
    .ad_os      (os),
    .ad_busy    (f_busy),
    .first_data (f_fd),
    .ad_data    (f_data),
    .conv_ovr   (f_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic conv(input logic [2:0] o, input int ovr_at,
                      input int exp_w, input string tag);
    int w;
    @(negedge clk);
    os = o;
    convstab = 1'b0;
    repeat (3) @(negedge clk);
    convstab = 1'b1;
    @(negedge clk);
    chk({tag, "_rise"}, 32'(busy), 32'd1);
    w = 0;
    while (busy && w < 20000) begin
      w++;
      if (ovr_at != 0 && w == ovr_at)     convstab = 1'b0;
      if (ovr_at != 0 && w == ovr_at + 2) convstab = 1'b1;
      @(negedge clk);
    end
    chk({tag, "_width"}, 32'(w), 32'(exp_w));
  endtask

  task automatic rd_word(output logic [15:0] d, output logic f);
    @(negedge clk);
    rd = 1'b0;
    repeat (3) @(negedge clk);
    d = data;
    f = fd;
    rd = 1'b1;
  endtask

  task automatic fast_conv(output int w);
    @(negedge clk);
    f_convstab = 1'b0;
    @(negedge clk);
    f_convstab = 1'b1;
    @(negedge clk);
    w = 0;
    while (f_busy && w < 20) begin
      w++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic        f;
    int          w;
    longint      wsum;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    ad_reset = 1'b0;
    convstab = 1'b1;
    f_convstab = 1'b1;
    cs = 1'b1;
    f_cs = 1'b1;
    rd = 1'b1;
    os = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd",   32'(fd),   32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ovr",  32'(ovr),  32'd0);

    conv(3'd0, 0, 201, "c0");
    cs = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_word(d, f);
      chk($sformatf("c0_ch%0d", k + 1), 32'(d), 32'(k) << 13);
      chk($sformatf("c0_fd%0d", k + 1), 32'(f), 32'(k == 0));
    end
    cs = 1'b1;

    conv(3'd0, 0, 201, "c1");
    cs = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_word(d, f);
      chk($sformatf("c1_ch%0d", k + 1), 32'(d), (32'(k) << 13) | 32'd1);
    end
    cs = 1'b1;

    conv(3'd2, 0, 801, "os2");
    conv(3'd7, 0, 201, "os7");

    conv(3'd0, 50, 201, "ovr");
    chk("ovr_set", 32'(ovr), 32'd1);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", 32'(ovr), 32'd1);

    @(negedge clk);
    convstab = 1'b0;
    @(negedge clk);
    convstab = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    convstab = 1'b0;
    @(negedge clk);
    ad_reset = 1'b1;
    convstab = 1'b1;
    @(negedge clk);
    ad_reset = 1'b0;
    chk("adrst_busy", 32'(busy), 32'd0);
    chk("adrst_ovr",  32'(ovr),  32'd0);
    chk("adrst_data", 32'(data), 32'd0);
    chk("adrst_fd",   32'(fd),   32'd0);
    repeat (5) @(negedge clk);
    chk("no_restart", 32'(busy), 32'd0);

    conv(3'd0, 0, 201, "c_post");
    cs = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd_word(d, f);
      chk($sformatf("r10_d%0d", k + 1), 32'(d), 32'(k % 8) << 13);
      chk($sformatf("r10_fd%0d", k + 1), 32'(f),
          32'(k == 0 || k == 8));
    end
    cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("cs_hi_fd",   32'(fd),   32'd0);
    chk("cs_hi_hold", 32'(data), 32'h2000);
    cs = 1'b0;
    for (int k = 0; k < 4; k++) rd_word(d, f);
    chk("r4_ch4", 32'(d), 32'h6000);
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    rd_word(d, f);
    chk("cs_rst_ch1", 32'(d), 32'h0000);
    chk("cs_rst_fd",  32'(f), 32'd1);
    cs = 1'b1;

    os = 3'd0;
    wsum = 0;
    for (int n = 0; n < 8192; n++) begin
      fast_conv(w);
      wsum += w;
    end
    chk("fast_wsum", 32'(wsum), 32'(8192 * 2));
    f_cs = 1'b0;
    rd_word(d, f);
    chk("wrap_pre_ch1", 32'(f_data), 32'h1FFF);
    chk("wrap_pre_fd",  32'(f_fd),   32'd1);
    f_cs = 1'b1;
    fast_conv(w);
    chk("fast_last_w", 32'(w), 32'd2);
    f_cs = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_word(d, f);
      if (k == 0) begin
        chk("wrap_ch1", 32'(f_data), 32'h0000);
        chk("wrap_fd",  32'(f_fd),   32'd1);
      end
    end
    chk("wrap_ch8", 32'(f_data), 32'hE000);
    f_cs = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
